fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded at reset.
REQ-002 Parameter QDEPTH, default 2: fetch queue entries; the only legal value is 2.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 imem_a  output  32  instruction memory byte address; always equals the fetch PC.
REQ-006 imem_rd  input  32  instruction word returned combinationally for imem_a in the same cycle.
REQ-007 redirect_valid  input  1  branch/jump/exception redirect request.
REQ-008 redirect_pc  input  32  redirect target; bits [1:0] ignored.
REQ-009 out_valid  output  1  queue head holds a valid instruction.
REQ-010 out_ready  input  1  decode accepts the head this cycle.
REQ-011 out_instr  output  32  head instruction word.
REQ-012 out_pc  output  32  head instruction address.
REQ-013 out_pc_plus4  output  32  out_pc + 4, modulo 2^32.

Function
REQ-014 Fetch PC register pc_f SHALL drive imem_a directly, with no combinational path from redirect_pc.
REQ-015 Enqueue SHALL occur on a rising edge when redirect_valid=0 and (count<2 or a dequeue occurs that edge); the entry is {pc_f, imem_rd} and pc_f becomes pc_f+4.
REQ-016 Dequeue SHALL occur on a rising edge when out_valid=1 and out_ready=1 and redirect_valid=0.
REQ-017 Queue SHALL be FIFO with count 0..2; simultaneous enqueue and dequeue at count=2 keeps count at 2 and preserves order.
REQ-018 While count=2 and no dequeue, pc_f SHALL hold and no fetch is lost or duplicated.
REQ-019 out_valid SHALL equal (count>0); out_instr/out_pc SHALL be the head entry, held stable while out_valid=1 and out_ready=0.
REQ-020 Redirect SHALL have priority over enqueue and dequeue: on that edge count<=0 and pc_f<={redirect_pc[31:2],2'b00}; out_valid is 0 the following cycle.
REQ-021 After a redirect, the first enqueued entry SHALL carry out_pc = aligned redirect_pc, valid one cycle after the redirect edge.
REQ-022 PC arithmetic SHALL wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-023 Latency: an instruction fetched at edge N SHALL be visible on out_* in cycle N+1 when the queue was empty.
REQ-024 Throughput: with out_ready held at 1 and no redirect, one instruction SHALL be delivered per cycle.

Reset
REQ-025 While reset_n=0: pc_f=RESET_PC, count=0, out_valid=0, out_instr=0, out_pc=0, out_pc_plus4=4; assertion mid-operation discards all queue contents immediately.
REQ-026 The first enqueue SHALL occur on the first rising edge after reset_n deasserts.

Structure
REQ-027 XLEN=32, RESET_PC default and the fetch-entry struct {pc, instr} SHALL live in the shared package riscv_pkg.
REQ-028 The 2-entry queue SHALL be a sub-module fetch_queue (push/pop/flush, count, head); pc_f and next-PC selection stay in fetch_unit.

Verification
REQ-029 imem holds 01400093, 00500113, 0220d1b3 at 0x0, 0x4, 0x8; reset release with out_ready=1 -> out_pc 0x0, 0x4, 0x8 on consecutive cycles with matching out_instr.
REQ-030 out_ready=0 for 5 cycles after reset -> count saturates at 2, imem_a holds at 0x8, and out_instr=01400093 stable; releasing out_ready then delivers 0x0, 0x4, 0x8 in order with no gap.
REQ-031 redirect_valid=1 with redirect_pc=0x0000_0013 while count=2 -> next cycle out_valid=0, imem_a=0x10; the following cycle out_pc=0x10.
REQ-032 redirect_valid=1 coincident with out_ready=1 and count=1 -> no dequeue is counted, and the next delivered out_pc is the redirect target.
REQ-033 redirect to 0xFFFF_FFFC with out_ready=1 -> out_pc 0xFFFF_FFFC, then 0x0000_0000, with out_pc_plus4 0x0000_0000 for the first.
REQ-034 reset_n pulsed low for 3 ns mid-stream, asynchronous to clk -> out_valid drops immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core types: machine width, reset vector and the fetch-entry bundle.
// Imported by the fetch unit, its queue and its bus interface.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] INSN_BYTES = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(
        input logic [XLEN-1:0] a
    );
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: instruction memory port, redirect request and the
// valid/ready handshake towards decode.
interface fetch_unit_if;
    import riscv_pkg::*;

    logic [XLEN-1:0] imem_a;
    logic [XLEN-1:0] imem_rd;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pc_plus4;

    modport master (
        output imem_a,
        input  imem_rd,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output out_pc_plus4
    );

    modport slave (
        input  imem_a,
        output imem_rd,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  out_pc_plus4
    );

endinterface

// File: rtl/fetch_queue.sv
// Small circular FIFO of fetch entries with flush; the head is always
// presented so decode sees it the cycle after it was written.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic         i_pop,
    input  fetch_entry_t i_entry,
    output logic [CW-1:0] o_count,
    output fetch_entry_t o_head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_entry;
                r_wr        <= ptr_inc(r_wr);
            end
            if (i_pop) begin
                r_rd <= ptr_inc(r_rd);
            end
            // push and pop together at full reuse the slot being vacated
            unique case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: fetch PC register, next-PC selection and a two-entry
// queue decoupling the instruction memory from decode back-pressure.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              QDEPTH   = 2
) (
    input  logic clk,
    input  logic reset_n,
    fetch_unit_if.master bus
);

    localparam int CW = $clog2(QDEPTH + 1);

    logic [XLEN-1:0] r_pc_f;
    logic [XLEN-1:0] w_pc_next;
    logic [CW-1:0]   w_count;
    logic            w_valid;
    logic            w_full;
    logic            w_redir;
    logic            w_push;
    logic            w_pop;
    fetch_entry_t    w_entry;
    fetch_entry_t    w_head;

    assign w_redir = bus.redirect_valid;
    assign w_valid = (w_count != '0);
    assign w_full  = (w_count == CW'(QDEPTH));

    // a redirect squashes both queue ends on the same edge
    assign w_pop  = w_valid && bus.out_ready && !w_redir;
    assign w_push = !w_redir && (!w_full || w_pop);

    assign w_entry.pc    = r_pc_f;
    assign w_entry.instr = bus.imem_rd;

    always_comb begin
        w_pc_next = r_pc_f;
        unique case (1'b1)
            w_redir: w_pc_next = align_word(bus.redirect_pc);
            w_push:  w_pc_next = r_pc_f + INSN_BYTES;
            default: w_pc_next = r_pc_f;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc_f <= RESET_PC;
        end else begin
            r_pc_f <= w_pc_next;
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH),
        .CW    (CW)
    ) u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .i_flush (w_redir),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_entry (w_entry),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign bus.imem_a       = r_pc_f;
    assign bus.out_valid    = w_valid;
    assign bus.out_instr    = w_head.instr;
    assign bus.out_pc       = w_head.pc;
    assign bus.out_pc_plus4 = w_head.pc + INSN_BYTES;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random ready/redirect
// traffic, checked by a scoreboard of the expected instruction stream.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk;
    logic reset_n;
    logic since;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_deliv  = 0;
    exp_t exp_q[$];

    fetch_unit_if bus();

    fetch_unit #(
        .RESET_PC (RST_PC),
        .QDEPTH   (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0140_0093;
            32'h0000_0004: return 32'h0050_0113;
            32'h0000_0008: return 32'h0220_d1b3;
            default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        endcase
    endfunction

    assign bus.imem_rd = imem_word(bus.imem_a);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // expected stream after a flush: consecutive words from the target
    task automatic restart_stream(input logic [31:0] tgt);
        logic [31:0] a;
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            exp_t e;
            a = tgt + 32'(4 * i);
            e.pc = a;
            e.instr = imem_word(a);
            exp_q.push_back(e);
        end
    endtask

    // decode may see an instruction once an unsquashed edge has passed
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) since <= 1'b0;
        else          since <= !bus.redirect_valid;
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            check("rst_valid", 32'(bus.out_valid), 32'd0);
            check("rst_instr", bus.out_instr, 32'd0);
            check("rst_pc", bus.out_pc, 32'd0);
            check("rst_pc4", bus.out_pc_plus4, 32'd4);
            check("rst_imem_a", bus.imem_a, RST_PC);
        end else begin
            check("out_valid", 32'(bus.out_valid), 32'(since));
            if (bus.out_valid && !bus.redirect_valid) begin
                if (exp_q.size() == 0) begin
                    check("sb_empty", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q[0];
                    check("out_pc", bus.out_pc, e.pc);
                    check("out_instr", bus.out_instr, e.instr);
                    check("out_pc4", bus.out_pc_plus4, e.pc + 32'd4);
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        n_deliv++;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        restart_stream(RST_PC);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = tgt;
        restart_stream({tgt[31:2], 2'b00});
    endtask

    initial begin
        int d0;
        logic [31:0] tgt;
        reset_n = 1'b0;
        bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'd0;
        restart_stream(RST_PC);

        // back-to-back stream from reset
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        d0 = n_deliv;
        repeat (4) @(posedge clk);
        #2;
        check("stream_deliv", 32'(n_deliv - d0), 32'd3);

        // decode stalled: queue fills and the fetch PC holds
        bus.out_ready = 1'b0;
        do_reset();
        repeat (5) @(posedge clk);
        #3;
        check("full_imem_a", bus.imem_a, 32'h0000_0008);
        check("full_instr", bus.out_instr, 32'h0140_0093);
        bus.out_ready = 1'b1;
        d0 = n_deliv;
        repeat (3) @(negedge clk);
        #1;
        check("drain_nogap", 32'(n_deliv - d0), 32'd3);

        // misaligned redirect while full
        @(posedge clk);
        #2;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        redirect(32'h0000_0013);
        @(posedge clk);
        #2;
        bus.redirect_valid = 1'b0;
        bus.out_ready = 1'b1;
        check("redir_valid0", 32'(bus.out_valid), 32'd0);
        check("redir_imem_a", bus.imem_a, 32'h0000_0010);
        @(posedge clk);
        #2;
        check("redir_pc", bus.out_pc, 32'h0000_0010);

        // redirect beats a dequeue at count 1
        repeat (2) @(posedge clk);
        #2;
        d0 = n_deliv;
        redirect(32'h0000_0200);
        @(posedge clk);
        #2;
        bus.redirect_valid = 1'b0;
        check("redir_nodeq", 32'(n_deliv - d0), 32'd0);
        @(posedge clk);
        #2;
        check("redir_tgt", bus.out_pc, 32'h0000_0200);

        // PC wrap
        @(posedge clk);
        #2;
        redirect(32'hFFFF_FFFC);
        @(posedge clk);
        #2;
        bus.redirect_valid = 1'b0;
        @(posedge clk);
        #2;
        check("wrap_pc", bus.out_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", bus.out_pc_plus4, 32'h0000_0000);
        @(posedge clk);
        #2;
        check("wrap_next", bus.out_pc, 32'h0000_0000);

        // short asynchronous reset pulse mid-stream
        repeat (3) @(posedge clk);
        #6;
        reset_n = 1'b0;
        restart_stream(RST_PC);
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 32'd0);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #2;
        check("async_rst_pc", bus.out_pc, RST_PC);
        check("async_rst_v1", 32'(bus.out_valid), 32'd1);

        // random back-pressure and redirects
        d0 = n_deliv;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #2;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 11) == 0) begin
                case ($urandom_range(0, 2))
                    0:       tgt = $urandom();
                    1:       tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                    default: tgt = 32'($urandom_range(0, 255));
                endcase
                redirect(tgt);
            end else begin
                bus.redirect_valid = 1'b0;
            end
        end
        @(posedge clk);
        #2;
        bus.redirect_valid = 1'b0;
        check("rand_liveness", 32'(n_deliv - d0 >= 1000), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
